// File: rtl/demux2_pkg.sv
// ----------------------------------------------------------------------------
// demux2_pkg
// Shared definitions for the demux2 routing slice: default data width, the
// buffered route entry layout {dst, data}, port identifiers and a small helper
// that looks up a port's enable bit.
// ----------------------------------------------------------------------------
package demux2_pkg;

    localparam int DATA_SIZE = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Entry as stored in the input buffer; dst sits above the data so the
    // packed form matches {in_dst, in_data}.
    typedef struct packed {
        logic                 dst;
        logic [DATA_SIZE-1:0] data;
    } route_entry_t;

    function automatic logic port_enabled(input logic [1:0] en, input logic dst);
        return en[dst];
    endfunction

endpackage

// File: rtl/route_fifo.sv
// ----------------------------------------------------------------------------
// route_fifo
// Synchronous FIFO holding tagged route entries for demux2_route_ctrl.
// The head entry is presented combinationally on o_rdata.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_push       write i_wdata at the tail (caller guarantees not full unless popping)
//   i_pop        retire the head entry (caller guarantees not empty)
//   i_wdata      entry to write
//   o_rdata      current head entry
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_count      number of buffered entries
// ----------------------------------------------------------------------------
module route_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count is
    // one bit wider so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/demux2_route_ctrl.sv
// ----------------------------------------------------------------------------
// demux2_route_ctrl
// Buffers tagged words from a single producer and steers each, in arrival
// order, to consumer port 0 or 1 by driving the external demux2 select/data and
// one port valid at a time. Words whose destination port is disabled are
// dropped and counted in a saturating counter.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   i_in_valid/o_in_ready producer handshake; i_in_data + i_in_dst form the word
//   i_port_en             per-port enable, evaluated against the current head
//   o_demux_sel/o_demux_din  drive demux2 sel/din
//   o_out0_valid/i_out0_ready, o_out1_valid/i_out1_ready  consumer handshakes
//   o_drop_cnt            saturating count of dropped words
//   o_busy                buffer non-empty
// ----------------------------------------------------------------------------
module demux2_route_ctrl
    import demux2_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int fifo_depth = 4,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [data_size-1:0] i_in_data,
    input  logic                 i_in_dst,
    input  logic [1:0]           i_port_en,
    output logic                 o_demux_sel,
    output logic [data_size-1:0] o_demux_din,
    output logic                 o_out0_valid,
    input  logic                 i_out0_ready,
    output logic                 o_out1_valid,
    input  logic                 i_out1_ready,
    output logic [cnt_width-1:0] o_drop_cnt,
    output logic                 o_busy
);

    localparam int AW = $clog2(fifo_depth);

    logic [data_size:0]   w_head;
    logic                 w_head_dst;
    logic [data_size-1:0] w_head_data;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          w_count;
    logic                 w_head_en;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_deliver;
    logic                 w_drop;
    logic                 r_last_sel;
    logic [cnt_width-1:0] r_drop_cnt;

    route_fifo #(
        .WIDTH (data_size + 1),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({i_in_dst, i_in_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_dst  = w_head[data_size];
    assign w_head_data = w_head[data_size-1:0];
    assign w_head_en   = port_enabled(i_port_en, w_head_dst);

    // Only the head is ever offered, so at most one valid can be high and a
    // blocked head holds back everything behind it.
    assign o_out0_valid = !w_empty && (w_head_dst == PORT0) && w_head_en;
    assign o_out1_valid = !w_empty && (w_head_dst == PORT1) && w_head_en;

    assign w_deliver = (o_out0_valid && i_out0_ready) || (o_out1_valid && i_out1_ready);
    assign w_drop    = !w_empty && !w_head_en;
    assign w_pop     = w_deliver || w_drop;

    // A retiring head frees a slot in the same cycle, so a full buffer can
    // still accept when it is also popping.
    assign o_in_ready = !w_full || w_pop;
    assign w_push     = i_in_valid && o_in_ready;

    assign o_demux_sel = w_empty ? r_last_sel : w_head_dst;
    assign o_demux_din = w_empty ? '0 : w_head_data;
    assign o_busy      = (w_count != '0);
    assign o_drop_cnt  = r_drop_cnt;

    // Remember the last head destination so the demux select stays put while
    // the buffer is empty, and count drops without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sel <= PORT0;
            r_drop_cnt <= '0;
        end else begin
            if (!w_empty) begin
                r_last_sel <= w_head_dst;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux2_route_ctrl.sv
// ----------------------------------------------------------------------------
// tb_demux2_route_ctrl
// Directed testbench for demux2_route_ctrl: reset, routing, backpressure with
// a full buffer, head-of-line blocking, drops with saturation and withdrawal
// of a port enable while a word is being offered.
// ----------------------------------------------------------------------------
module tb_demux2_route_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_dst;
    logic [1:0]  port_en;
    logic        demux_sel;
    logic [31:0] demux_din;
    logic        out0_valid;
    logic        out0_ready;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    demux2_route_ctrl #(
        .data_size  (32),
        .fifo_depth (4),
        .cnt_width  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .i_in_dst     (in_dst),
        .i_port_en    (port_en),
        .o_demux_sel  (demux_sel),
        .o_demux_din  (demux_din),
        .o_out0_valid (out0_valid),
        .i_out0_ready (out0_ready),
        .o_out1_valid (out1_valid),
        .i_out1_ready (out1_ready),
        .o_drop_cnt   (drop_cnt),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then changed and
    // outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dst = 1'b0;
        port_en = 2'b11; out0_ready = 1'b0; out1_ready = 1'b0;
        tick(); tick();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valids got=%b%b exp=00", out1_valid, out0_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++; if (demux_sel !== 1'b0 || demux_din !== 32'd0) begin failures++; $display("[TB] FAIL reset_demux got sel=%b din=%h exp sel=0 din=0", demux_sel, demux_din); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        // Load two words with the consumer stalled, then reset mid-stream.
        in_valid = 1'b1; in_dst = 1'b0; in_data = 32'h1111_0000;
        tick();
        in_data = 32'h1111_0001;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL prereset_load got valid=%b busy=%b exp 1 1", out0_valid, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_async got valid=%b busy=%b exp 0 0", out0_valid, busy); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("[TB] FAIL postreset got ready=%b busy=%b drop=%0d exp 1 0 0", in_ready, busy, drop_cnt); end
    endtask

    task automatic test_routing();
        port_en = 2'b11; out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_dst = 1'b0; in_data = 32'hA5A5_0001;
        tick();
        in_dst = 1'b1; in_data = 32'h5A5A_0002;
        #1;
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || demux_sel !== 1'b0 || demux_din !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL route_word0 got v0=%b v1=%b sel=%b din=%h exp 1 0 0 a5a50001", out0_valid, out1_valid, demux_sel, demux_din); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b1 || out0_valid !== 1'b0 || demux_sel !== 1'b1 || demux_din !== 32'h5A5A_0002) begin failures++; $display("[TB] FAIL route_word1 got v0=%b v1=%b sel=%b din=%h exp 0 1 1 5a5a0002", out0_valid, out1_valid, demux_sel, demux_din); end
        tick();
        checks++; if (busy !== 1'b0 || demux_sel !== 1'b1 || demux_din !== 32'd0) begin failures++; $display("[TB] FAIL route_empty got busy=%b sel=%b din=%h exp 0 1 0", busy, demux_sel, demux_din); end
    endtask

    task automatic test_back_to_back_full();
        out0_ready = 1'b0; port_en = 2'b11; in_dst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h0000_0100 + 32'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
        end
        in_data = 32'h0000_0104;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", in_ready); end
        checks++; if (out0_valid !== 1'b1 || demux_din !== 32'h0000_0100) begin failures++; $display("[TB] FAIL full_head got v=%b din=%h exp 1 00000100", out0_valid, demux_din); end
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out0_valid !== 1'b1 || demux_din !== 32'h0000_0101 + 32'(i)) begin failures++; $display("[TB] FAIL drain[%0d] got v=%b din=%h exp 1 %h", i, out0_valid, demux_din, 32'h0000_0101 + 32'(i)); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty got busy=%b exp=0", busy); end
    endtask

    task automatic test_hol_block();
        port_en = 2'b11; out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_dst = 1'b1; in_data = 32'h0000_00B1;
        tick();
        in_dst = 1'b0; in_data = 32'h0000_00B0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out1_valid !== 1'b1 || out0_valid !== 1'b0 || demux_din !== 32'h0000_00B1) begin failures++; $display("[TB] FAIL hol_hold[%0d] got v0=%b v1=%b din=%h exp 0 1 000000b1", i, out0_valid, out1_valid, demux_din); end
            tick();
        end
        out1_ready = 1'b1;
        tick();
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || demux_din !== 32'h0000_00B0 || demux_sel !== 1'b0) begin failures++; $display("[TB] FAIL hol_release got v0=%b v1=%b sel=%b din=%h exp 1 0 0 000000b0", out0_valid, out1_valid, demux_sel, demux_din); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL hol_empty got busy=%b exp=0", busy); end
    endtask

    task automatic test_drop();
        port_en = 2'b01; out1_ready = 1'b1;
        in_valid = 1'b1; in_dst = 1'b1; in_data = 32'h0000_00D0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out1_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_novalid[%0d] got=%b exp=0", i, out1_valid); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (drop_cnt !== 8'd3 || busy !== 1'b0) begin failures++; $display("[TB] FAIL drop_count got cnt=%0d busy=%b exp 3 0", drop_cnt, busy); end
        // 261 further drops take the total to 264, past the 8-bit limit.
        in_valid = 1'b1;
        for (int i = 0; i < 261; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (drop_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL drop_saturate got=%h exp=ff", drop_cnt); end
        port_en = 2'b11;
    endtask

    task automatic test_enable_withdrawn();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("[TB] FAIL withdraw_reset_cnt got=%0d exp=0", drop_cnt); end
        port_en = 2'b11; out1_ready = 1'b0;
        tick();
        in_valid = 1'b1; in_dst = 1'b1; in_data = 32'h0000_00E1;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b1) begin failures++; $display("[TB] FAIL withdraw_valid got=%b exp=1", out1_valid); end
        port_en = 2'b01;
        #1;
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("[TB] FAIL withdraw_fall got=%b exp=0", out1_valid); end
        tick();
        checks++; if (drop_cnt !== 8'd1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL withdraw_drop got cnt=%0d busy=%b exp 1 0", drop_cnt, busy); end
        port_en = 2'b11;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_back_to_back_full();
        test_hol_block();
        test_drop();
        test_enable_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
